// File: rtl/candidate_collector.sv
// Collects I2LBS face-candidate windows per frame into a FWFT result FIFO for the OS-side reader.
// Optional macro CANDIDATE_DEDUP_EN suppresses candidates adjacent (+/-1) to the last stored one.
module candidate_collector #(
    parameter int unsigned DATA_WIDTH_12 = 12,
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter int unsigned ADDR_WIDTH    = 4,
    parameter int unsigned COUNT_WIDTH   = 8
) (
    input  logic                     clk_fpga,
    input  logic                     reset_fpga,
    input  logic                     i_frame_start,
    input  logic                     i_frame_end,
    input  logic                     i_inspect_done,
    input  logic                     i_candidate,
    input  logic [DATA_WIDTH_12-1:0] i_resize_x,
    input  logic [DATA_WIDTH_12-1:0] i_resize_y,
    input  logic                     i_rd_ready,
    output logic                     o_rd_valid,
    output logic [DATA_WIDTH_12-1:0] o_rd_x,
    output logic [DATA_WIDTH_12-1:0] o_rd_y,
    output logic [ADDR_WIDTH:0]      o_fifo_count,
    output logic [COUNT_WIDTH-1:0]   o_frame_count,
    output logic                     o_overflow,
    output logic                     o_frame_done
);
    localparam int unsigned OCC_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, COLLECT, CLOSE} state_t;

    state_t                   state;
    logic [DATA_WIDTH_12-1:0] mem_x [FIFO_DEPTH];
    logic [DATA_WIDTH_12-1:0] mem_y [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]    wr_ptr;
    logic [ADDR_WIDTH-1:0]    rd_ptr;
    logic [COUNT_WIDTH-1:0]   run_count;
    logic                     full;
    logic                     pop;
    logic                     dup;
    logic                     push_evt;
    logic                     wr_en;
    logic                     drop;
    logic                     start_seen;

    assign o_rd_valid = (o_fifo_count != '0);
    assign o_rd_x     = o_rd_valid ? mem_x[rd_ptr] : '0;
    assign o_rd_y     = o_rd_valid ? mem_y[rd_ptr] : '0;
    assign full       = (o_fifo_count == OCC_W'(FIFO_DEPTH));
    assign pop        = o_rd_valid && i_rd_ready;
    assign push_evt   = (state == COLLECT) && i_inspect_done && i_candidate && !dup;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign wr_en      = push_evt && (!full || pop);
    assign drop       = push_evt && full && !pop;
    assign start_seen = i_frame_start && ((state == IDLE) || (state == COLLECT));

`ifdef CANDIDATE_DEDUP_EN
    logic                     last_valid;
    logic [DATA_WIDTH_12-1:0] last_x;
    logic [DATA_WIDTH_12-1:0] last_y;
    logic                     near_x;
    logic                     near_y;

    assign near_x = (i_resize_x >= last_x) ? ((i_resize_x - last_x) <= DATA_WIDTH_12'(1))
                                           : ((last_x - i_resize_x) <= DATA_WIDTH_12'(1));
    assign near_y = (i_resize_y >= last_y) ? ((i_resize_y - last_y) <= DATA_WIDTH_12'(1))
                                           : ((last_y - i_resize_y) <= DATA_WIDTH_12'(1));
    assign dup    = last_valid && near_x && near_y;

    // Reference point for adjacency: only coordinates actually written to the FIFO.
    always_ff @(posedge clk_fpga or posedge reset_fpga) begin
        if (reset_fpga) begin
            last_valid <= 1'b0;
            last_x     <= '0;
            last_y     <= '0;
        end else if (start_seen) begin
            last_valid <= 1'b0;
        end else if (wr_en) begin
            last_valid <= 1'b1;
            last_x     <= i_resize_x;
            last_y     <= i_resize_y;
        end
    end
`else
    assign dup = 1'b0;
`endif

    // Result storage; contents are only observable through the valid-gated head.
    always_ff @(posedge clk_fpga) begin
        if (wr_en) begin
            mem_x[wr_ptr] <= i_resize_x;
            mem_y[wr_ptr] <= i_resize_y;
        end
    end

    always_ff @(posedge clk_fpga or posedge reset_fpga) begin
        if (reset_fpga) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            o_fifo_count <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (pop)   rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            case ({wr_en, pop})
                2'b10:   o_fifo_count <= o_fifo_count + OCC_W'(1);
                2'b01:   o_fifo_count <= o_fifo_count - OCC_W'(1);
                default: o_fifo_count <= o_fifo_count;
            endcase
        end
    end

    // Frame FSM with per-frame counter and sticky overflow.
    always_ff @(posedge clk_fpga or posedge reset_fpga) begin
        if (reset_fpga) begin
            state         <= IDLE;
            run_count     <= '0;
            o_overflow    <= 1'b0;
            o_frame_count <= '0;
            o_frame_done  <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_frame_start) begin
                        state      <= COLLECT;
                        run_count  <= '0;
                        o_overflow <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (i_frame_start) begin
                        run_count  <= wr_en ? COUNT_WIDTH'(1) : '0;
                        o_overflow <= drop;
                    end else begin
                        if (wr_en && (run_count != '1)) run_count <= run_count + COUNT_WIDTH'(1);
                        if (drop) o_overflow <= 1'b1;
                    end
                    if (i_frame_end) state <= CLOSE;
                end
                CLOSE: begin
                    o_frame_count <= run_count;
                    o_frame_done  <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_candidate_collector.sv
// Directed self-checking bench for candidate_collector: vector table plus hand-written corner sequences.
module tb_candidate_collector;
    logic        clk = 1'b0;
    logic        rst;
    logic        fs, fe, insp, cand, rdy;
    logic [11:0] x, y;
    logic        rd_valid;
    logic [11:0] rd_x, rd_y;
    logic [4:0]  fifo_count;
    logic [7:0]  frame_count;
    logic        overflow, frame_done;

    int nchecks = 0;
    int nerr    = 0;

    always #5 clk = ~clk;

    candidate_collector dut (
        .clk_fpga      (clk),
        .reset_fpga    (rst),
        .i_frame_start (fs),
        .i_frame_end   (fe),
        .i_inspect_done(insp),
        .i_candidate   (cand),
        .i_resize_x    (x),
        .i_resize_y    (y),
        .i_rd_ready    (rdy),
        .o_rd_valid    (rd_valid),
        .o_rd_x        (rd_x),
        .o_rd_y        (rd_y),
        .o_fifo_count  (fifo_count),
        .o_frame_count (frame_count),
        .o_overflow    (overflow),
        .o_frame_done  (frame_done)
    );

    typedef struct {
        logic        fs, fe, insp, cand;
        logic [11:0] x, y;
        logic        rdy;
        logic        ev;
        logic [11:0] ex, ey;
        logic [4:0]  ecnt;
        logic [7:0]  efc;
        logic        eovf, edone;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(logic a_fs, logic a_fe, logic a_insp, logic a_cand, int a_x, int a_y,
                                logic a_rdy, logic a_ev, int a_ex, int a_ey, int a_cnt, int a_fc,
                                logic a_ovf, logic a_done);
        vec_t v;
        v.fs = a_fs; v.fe = a_fe; v.insp = a_insp; v.cand = a_cand;
        v.x = 12'(a_x); v.y = 12'(a_y); v.rdy = a_rdy;
        v.ev = a_ev; v.ex = 12'(a_ex); v.ey = 12'(a_ey);
        v.ecnt = 5'(a_cnt); v.efc = 8'(a_fc); v.eovf = a_ovf; v.edone = a_done;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        nchecks++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic a_fs, input logic a_fe, input logic a_insp, input logic a_cand,
                         input int a_x, input int a_y, input logic a_rdy);
        fs = a_fs; fe = a_fe; insp = a_insp; cand = a_cand;
        x = 12'(a_x); y = 12'(a_y); rdy = a_rdy;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int a_x, input int a_y);
        drive(0, 0, 1, 1, a_x, a_y, 0);
        step();
        idle();
    endtask

    // Steps idle cycles until the frame-done pulse is seen, bounded.
    task automatic wait_done(input string name);
        int seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (frame_done) begin
                seen = 1;
                break;
            end
            step();
        end
        chk(name, seen, 1);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", int'(rd_valid), 0);
        chk("reset_count", int'(fifo_count), 0);
        chk("reset_fc", int'(frame_count), 0);
        chk("reset_ovf", int'(overflow), 0);
        chk("reset_done", int'(frame_done), 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic frame, reads in order, IDLE candidate dropped, candidate coincident with frame end kept.
        vecs[0]  = mk(1,0,0,0, 0,0, 0,  0, 0,0, 0, 0, 0,0);
        vecs[1]  = mk(0,0,1,1, 5,7, 0,  1, 5,7, 1, 0, 0,0);
        vecs[2]  = mk(0,0,1,1, 9,2, 0,  1, 5,7, 2, 0, 0,0);
        vecs[3]  = mk(0,0,1,0, 1,1, 0,  1, 5,7, 2, 0, 0,0);
        vecs[4]  = mk(0,1,0,0, 0,0, 0,  1, 5,7, 2, 0, 0,0);
        vecs[5]  = mk(0,0,0,0, 0,0, 1,  1, 9,2, 1, 2, 0,1);
        vecs[6]  = mk(0,0,0,0, 0,0, 1,  0, 0,0, 0, 2, 0,0);
        vecs[7]  = mk(0,0,0,0, 0,0, 1,  0, 0,0, 0, 2, 0,0);
        vecs[8]  = mk(0,0,1,1, 4,4, 0,  0, 0,0, 0, 2, 0,0);
        vecs[9]  = mk(1,0,0,0, 0,0, 0,  0, 0,0, 0, 2, 0,0);
        vecs[10] = mk(0,1,1,1, 6,8, 0,  1, 6,8, 1, 2, 0,0);
        vecs[11] = mk(0,0,0,0, 0,0, 0,  1, 6,8, 1, 1, 0,1);
        vecs[12] = mk(0,0,0,0, 0,0, 1,  0, 0,0, 0, 1, 0,0);

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].fs, vecs[i].fe, vecs[i].insp, vecs[i].cand,
                  int'(vecs[i].x), int'(vecs[i].y), vecs[i].rdy);
            step();
            chk($sformatf("v%0d_valid", i), int'(rd_valid), int'(vecs[i].ev));
            chk($sformatf("v%0d_x", i), int'(rd_x), int'(vecs[i].ex));
            chk($sformatf("v%0d_y", i), int'(rd_y), int'(vecs[i].ey));
            chk($sformatf("v%0d_fifo_count", i), int'(fifo_count), int'(vecs[i].ecnt));
            chk($sformatf("v%0d_frame_count", i), int'(frame_count), int'(vecs[i].efc));
            chk($sformatf("v%0d_overflow", i), int'(overflow), int'(vecs[i].eovf));
            chk($sformatf("v%0d_frame_done", i), int'(frame_done), int'(vecs[i].edone));
        end
        idle();

        // Overflow: 17 pushes into a 16-deep FIFO with no reads.
        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        idle();
        for (int i = 1; i <= 17; i++) push(3 * i, 3 * i + 100);
        chk("ovf_fifo_count", int'(fifo_count), 16);
        chk("ovf_sticky", int'(overflow), 1);
        chk("ovf_head_x", int'(rd_x), 3);
        chk("ovf_head_y", int'(rd_y), 103);
        drive(0, 1, 0, 0, 0, 0, 0);
        step();
        idle();
        wait_done("ovf_frame_done");
        chk("ovf_frame_count", int'(frame_count), 16);
        chk("ovf_held_after_close", int'(overflow), 1);

        // Full FIFO: simultaneous push and pop keeps occupancy and raises no overflow.
        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        chk("restart_ovf_clear", int'(overflow), 0);
        drive(0, 0, 1, 1, 3, 3, 1);
        step();
        idle();
        chk("pushpop_count", int'(fifo_count), 16);
        chk("pushpop_ovf", int'(overflow), 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        step();
        idle();
        wait_done("pushpop_frame_done");
        chk("pushpop_frame_count", int'(frame_count), 1);
        for (int i = 2; i <= 16; i++) begin
            chk($sformatf("drain%0d_x", i), int'(rd_x), 3 * i);
            chk($sformatf("drain%0d_y", i), int'(rd_y), 3 * i + 100);
            drive(0, 0, 0, 0, 0, 0, 1);
            step();
        end
        chk("drain_last_x", int'(rd_x), 3);
        chk("drain_last_y", int'(rd_y), 3);
        step();
        idle();
        chk("drain_empty", int'(fifo_count), 0);
        chk("drain_valid", int'(rd_valid), 0);

        // Asynchronous reset mid-frame with three stored entries.
        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        idle();
        push(20, 20);
        push(30, 30);
        push(40, 40);
        chk("pre_reset_count", int'(fifo_count), 3);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_valid", int'(rd_valid), 0);
        chk("async_reset_count", int'(fifo_count), 0);
        chk("async_reset_x", int'(rd_x), 0);
        step();
        rst = 1'b0;
        chk("post_reset_ovf", int'(overflow), 0);
        chk("post_reset_fc", int'(frame_count), 0);
        push(50, 50);
        chk("post_reset_idle_ignores", int'(fifo_count), 0);

        // Adjacent-coordinate suppression (only when built with dedup).
        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        idle();
        push(10, 10);
        push(11, 9);
        push(13, 10);
        drive(0, 1, 0, 0, 0, 0, 0);
        step();
        idle();
        wait_done("dedup_frame_done");
`ifdef CANDIDATE_DEDUP_EN
        chk("dedup_frame_count", int'(frame_count), 2);
        chk("dedup_fifo_count", int'(fifo_count), 2);
        chk("dedup_head0_x", int'(rd_x), 10);
        drive(0, 0, 0, 0, 0, 0, 1);
        step();
        chk("dedup_head1_x", int'(rd_x), 13);
        chk("dedup_head1_y", int'(rd_y), 10);
`else
        chk("dedup_frame_count", int'(frame_count), 3);
        chk("dedup_fifo_count", int'(fifo_count), 3);
        chk("dedup_head0_x", int'(rd_x), 10);
        drive(0, 0, 0, 0, 0, 0, 1);
        step();
        chk("dedup_head1_x", int'(rd_x), 11);
        chk("dedup_head1_y", int'(rd_y), 9);
`endif
        idle();

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end
endmodule
